// File: rtl/wb_seq_pkg.sv
// Shared constants and state encoding for the write-back sequencer.
// Mux codes double as request-bit indices and ack-bit indices.
package wb_seq_pkg;

    localparam logic [2:0] WB_ALU   = 3'd0;
    localparam logic [2:0] WB_MEM   = 3'd1;
    localparam logic [2:0] WB_HI    = 3'd2;
    localparam logic [2:0] WB_SP    = 3'd3;
    localparam logic [2:0] WB_LO    = 3'd4;
    localparam logic [2:0] WB_SHIFT = 3'd5;
    localparam logic [2:0] WB_SLT   = 3'd6;

    localparam logic [7:0] SP_INIT_VAL = 8'd227;
    localparam logic [4:0] SP_REG      = 5'd29;

    // Bit 3 is the internal SP-init source and never arbitrates.
    localparam logic [6:0] REQ_VALID_MASK = 7'b111_0111;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        MEM_WAIT,
        WRITE
    } wb_state_e;

endpackage

// File: rtl/wb_sequencer_if.sv
// Bundle between the write-back requesters and the sequencer, including the
// register-file write-port controls the sequencer drives.
interface wb_sequencer_if;

    logic [6:0]  req;
    logic [34:0] req_dst;
    logic [6:0]  ack;
    logic [2:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic        busy;
    logic        ready;

    modport master (
        output req, req_dst,
        input  ack, mem_to_reg, reg_write, write_reg, busy, ready
    );

    modport slave (
        input  req, req_dst,
        output ack, mem_to_reg, reg_write, write_reg, busy, ready
    );

endinterface

// File: rtl/wb_arbiter.sv
// Combinational write-back arbiter. Fixed priority 1>0>2>4>5>6 by default;
// round-robin over {0,1,2,4,5,6} starting after rr_ptr when WB_RR_EN is defined.
module wb_arbiter
    import wb_seq_pkg::*;
(
    input  logic [6:0] req,
`ifdef WB_RR_EN
    input  logic [2:0] rr_ptr,
`endif
    output logic       grant_valid,
    output logic [2:0] grant_code
);

`ifdef WB_RR_EN
    logic [7:0] req_ext;
    logic [3:0] sum;
    logic [2:0] cand;

    assign req_ext = {1'b0, req};

    // Scan from farthest to nearest offset so the nearest requester wins last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant_valid = 1'b0;
        grant_code  = WB_ALU;
        sum         = '0;
        cand        = '0;
        for (int off = 7; off >= 1; off--) begin
            sum  = {1'b0, rr_ptr} + 4'(off);
            cand = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (cand != WB_SP && req_ext[cand]) begin
                grant_valid = 1'b1;
                grant_code  = cand;
            end
        end
    end
`else
    logic unused_sp;
    assign unused_sp = req[WB_SP];

    always_comb begin
        grant_valid = req[WB_MEM] | req[WB_ALU] | req[WB_HI] |
                      req[WB_LO]  | req[WB_SHIFT] | req[WB_SLT];
        grant_code  = WB_ALU;
        if      (req[WB_MEM])   grant_code = WB_MEM;
        else if (req[WB_ALU])   grant_code = WB_ALU;
        else if (req[WB_HI])    grant_code = WB_HI;
        else if (req[WB_LO])    grant_code = WB_LO;
        else if (req[WB_SHIFT]) grant_code = WB_SHIFT;
        else if (req[WB_SLT])   grant_code = WB_SLT;
    end
`endif

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: SP init write after reset, then arbitrates the single
// register-file write port. Define WB_RR_EN for round-robin arbitration.
module wb_sequencer
    import wb_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
)
(
    input  logic          clk,
    input  logic          reset,
    wb_sequencer_if.slave bus
);

    wb_state_e  state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [4:0] dst_q, dst_d;
    logic [2:0] cnt_q, cnt_d;

    logic [6:0] ack_q, ack_d;
    logic [2:0] mux_q, mux_d;
    logic       we_q, we_d;
    logic [4:0] waddr_q, waddr_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    logic       grant_valid;
    logic [2:0] grant_code;
    logic [5:0] grant_lsb;
    logic [4:0] grant_dst;

    assign grant_lsb = 6'({grant_code, 2'b00}) + 6'(grant_code);
    assign grant_dst = bus.req_dst[grant_lsb +: 5];

`ifdef WB_RR_EN
    logic [2:0] ptr_q, ptr_d;

    wb_arbiter u_arbiter (
        .req         (bus.req & REQ_VALID_MASK),
        .rr_ptr      (ptr_q),
        .grant_valid (grant_valid),
        .grant_code  (grant_code)
    );

    // Pointer starts at SLT so the first search begins at ALU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= WB_SLT;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && grant_valid) ptr_d = grant_code;
    end
`else
    wb_arbiter u_arbiter (
        .req         (bus.req & REQ_VALID_MASK),
        .grant_valid (grant_valid),
        .grant_code  (grant_code)
    );
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        mux_d   = mux_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        ready_d = ready_q;

        case (state_q)
            // Reset leaves INIT with reg_write low; the first cycle issues the
            // SP write, the second (reg_write now high) moves on to IDLE.
            INIT: begin
                if (!we_q) begin
                    mux_d   = WB_SP;
                    waddr_d = SP_REG;
                    we_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (grant_valid) begin
                    code_d = grant_code;
                    dst_d  = grant_dst;
                    if (grant_code == WB_MEM) begin
                        state_d = MEM_WAIT;
                        cnt_d   = 3'(MEM_LAT);
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == 3'd1) state_d = WRITE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            WRITE:   state_d = IDLE;
            default: state_d = INIT;
        endcase

        // Outputs are registered from the state being entered, so WRITE
        // values appear on the same edge that grants a non-memory source.
        if (state_d == WRITE) begin
            mux_d   = code_d;
            waddr_d = dst_d;
            we_d    = (dst_d != 5'd0);
            ack_d   = 7'(1) << code_d;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            code_q  <= WB_ALU;
            dst_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            mux_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
            code_q  <= code_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            mux_q   <= mux_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.mem_to_reg = mux_q;
    assign bus.reg_write  = we_q;
    assign bus.write_reg  = waddr_q;
    assign bus.busy       = busy_q;
    assign bus.ready      = ready_q;

endmodule
